// File: rtl/multi_channel_integrator.sv
// multi_channel_integrator
//
// Purpose: accumulates a per-lane signed sum and an unsigned sum of squares
// for NUM_CH parallel sample lanes over a window. A window is either manual
// (int_start opens it, int_stop closes it) or automatic (closes after
// window_len samples and the next window follows with no gap). Each closed
// window is latched into registered outputs and offered on a valid/ready
// handshake. A result that is overwritten before it is accepted raises
// out_overrun.
//
// Optional feature: define MCI_MINMAX_EN to track per-lane running min/max.
// When it is undefined, out_min/out_max are driven to 0 and the port list
// is the same.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_data         NUM_CH signed lanes; lane k at [k*IN_DATA_WIDTH +: IN_DATA_WIDTH]
//   in_data_valid   all lanes carry a sample this cycle
//   int_start       open a window (ignored while a window is open)
//   int_stop        close the current window
//   auto_mode       1 = fixed-length back-to-back windows
//   window_len      samples per auto window (0 behaves as 1), captured on open/reload
//   out_data_sum    per-lane signed sums (ACC_WIDTH each)
//   out_data_sq     per-lane unsigned sums of squares (ACC_WIDTH each)
//   out_data_N      sample count of the window
//   out_sat         per-lane flag: an accumulator clamped during the window
//   out_min/out_max per-lane extrema (0 unless MCI_MINMAX_EN)
//   out_data_valid  result held until accepted
//   out_data_ready  consumer accepts on valid && ready
//   out_overrun     an unaccepted result was replaced
module multi_channel_integrator #(
  parameter int NUM_CH        = 4,
  parameter int IN_DATA_WIDTH = 16,
  parameter int ACC_WIDTH     = 64,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH*IN_DATA_WIDTH-1:0] in_data,
  input  logic                            in_data_valid,
  input  logic                            int_start,
  input  logic                            int_stop,
  input  logic                            auto_mode,
  input  logic [CNT_WIDTH-1:0]            window_len,
  output logic [NUM_CH*ACC_WIDTH-1:0]     out_data_sum,
  output logic [NUM_CH*ACC_WIDTH-1:0]     out_data_sq,
  output logic [CNT_WIDTH-1:0]            out_data_N,
  output logic [NUM_CH-1:0]               out_sat,
  output logic [NUM_CH*IN_DATA_WIDTH-1:0] out_min,
  output logic [NUM_CH*IN_DATA_WIDTH-1:0] out_max,
  output logic                            out_data_valid,
  input  logic                            out_data_ready,
  output logic                            out_overrun
);

  typedef enum logic {IDLE, INTEGRATE} state_t;

  state_t state_reg, state_next;

  logic                 open_now;
  logic                 active;
  logic                 take;
  logic                 close;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic [CNT_WIDTH-1:0] cnt_new;
  logic [CNT_WIDTH-1:0] win_len_reg;
  logic [CNT_WIDTH-1:0] len_eff;
  logic [CNT_WIDTH-1:0] win_eff;
  logic [CNT_WIDTH-1:0] out_n_reg;
  logic                 out_valid_reg;
  logic                 out_overrun_reg;

  assign len_eff = (window_len == '0) ? CNT_WIDTH'(1) : window_len;

  // Window control. A start seen in IDLE acts in the same cycle: the sample
  // of that cycle is included and the accumulators start from zero.
  always_comb begin
    open_now = (state_reg == IDLE) && int_start;
    active   = open_now || (state_reg == INTEGRATE);
    take     = active && in_data_valid;
    win_eff  = open_now ? len_eff : win_len_reg;
    cnt_base = open_now ? '0 : cnt_reg;
    cnt_new  = cnt_base;
    if (take && (cnt_base != '1)) begin
      cnt_new = cnt_base + CNT_WIDTH'(1);   // count saturates at all-ones
    end
    close      = active && (int_stop || (auto_mode && take && (cnt_new == win_eff)));
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (int_start && !int_stop) state_next = INTEGRATE;
      // An auto close without int_stop keeps integrating.
      INTEGRATE: if (int_stop) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg         <= '0;
      win_len_reg     <= '0;
      out_n_reg       <= '0;
      out_valid_reg   <= 1'b0;
      out_overrun_reg <= 1'b0;
    end else begin
      // Length is captured when a window opens and reloaded on every close.
      if (open_now || close) begin
        win_len_reg <= len_eff;
      end
      if (close) begin
        out_n_reg <= cnt_new;
        cnt_reg   <= '0;
      end else if (active) begin
        cnt_reg <= cnt_new;
      end
      // A close in the acceptance cycle keeps valid high with fresh data.
      if (close) begin
        out_valid_reg <= 1'b1;
      end else if (out_data_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (close && out_valid_reg && !out_data_ready) begin
        out_overrun_reg <= 1'b1;
      end else if (out_valid_reg && out_data_ready) begin
        out_overrun_reg <= 1'b0;
      end
    end
  end

  assign out_data_N     = out_n_reg;
  assign out_data_valid = out_valid_reg;
  assign out_overrun    = out_overrun_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic signed [IN_DATA_WIDTH-1:0]   x;
      logic signed [2*IN_DATA_WIDTH-1:0] x_wide;
      logic [2*IN_DATA_WIDTH-1:0]        x_sq;
      logic [ACC_WIDTH-1:0]              sum_reg, sum_base, sum_new;
      logic [ACC_WIDTH-1:0]              sq_reg, sq_base, sq_new;
      logic [ACC_WIDTH:0]                sum_ext, sq_ext;
      logic                              sat_reg, sat_base, sat_new;
      logic [ACC_WIDTH-1:0]              out_sum_reg, out_sq_reg;
      logic                              out_sat_reg;

      assign x      = in_data[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH];
      assign x_wide = {{IN_DATA_WIDTH{x[IN_DATA_WIDTH-1]}}, x};
      assign x_sq   = x_wide * x_wide;   // square is non-negative, fits 2*W bits

      // One guard bit above the accumulator exposes overflow of this step.
      always_comb begin
        sum_base = open_now ? '0 : sum_reg;
        sq_base  = open_now ? '0 : sq_reg;
        sat_base = open_now ? 1'b0 : sat_reg;
        sum_ext  = {sum_base[ACC_WIDTH-1], sum_base}
                 + {{(ACC_WIDTH+1-IN_DATA_WIDTH){x[IN_DATA_WIDTH-1]}}, x};
        sq_ext   = {1'b0, sq_base} + {{(ACC_WIDTH+1-2*IN_DATA_WIDTH){1'b0}}, x_sq};
        sum_new  = sum_base;
        sq_new   = sq_base;
        sat_new  = sat_base;
        if (take) begin
          if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
            sum_new = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            sat_new = 1'b1;
          end else begin
            sum_new = sum_ext[ACC_WIDTH-1:0];
          end
          if (sq_ext[ACC_WIDTH]) begin
            sq_new  = '1;
            sat_new = 1'b1;
          end else begin
            sq_new = sq_ext[ACC_WIDTH-1:0];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_reg     <= '0;
          sq_reg      <= '0;
          sat_reg     <= 1'b0;
          out_sum_reg <= '0;
          out_sq_reg  <= '0;
          out_sat_reg <= 1'b0;
        end else if (close) begin
          out_sum_reg <= sum_new;
          out_sq_reg  <= sq_new;
          out_sat_reg <= sat_new;
          sum_reg     <= '0;
          sq_reg      <= '0;
          sat_reg     <= 1'b0;
        end else if (active) begin
          sum_reg <= sum_new;
          sq_reg  <= sq_new;
          sat_reg <= sat_new;
        end
      end

      assign out_data_sum[gi*ACC_WIDTH +: ACC_WIDTH] = out_sum_reg;
      assign out_data_sq[gi*ACC_WIDTH +: ACC_WIDTH]  = out_sq_reg;
      assign out_sat[gi]                             = out_sat_reg;

`ifdef MCI_MINMAX_EN
      logic signed [IN_DATA_WIDTH-1:0] min_reg, min_base, min_new, out_min_reg;
      logic signed [IN_DATA_WIDTH-1:0] max_reg, max_base, max_new, out_max_reg;

      // The first sample of a window seeds both extrema; an empty window
      // keeps the cleared value of 0.
      always_comb begin
        min_base = open_now ? '0 : min_reg;
        max_base = open_now ? '0 : max_reg;
        min_new  = min_base;
        max_new  = max_base;
        if (take) begin
          if ((cnt_base == '0) || (x < min_base)) min_new = x;
          if ((cnt_base == '0) || (x > max_base)) max_new = x;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          min_reg     <= '0;
          max_reg     <= '0;
          out_min_reg <= '0;
          out_max_reg <= '0;
        end else if (close) begin
          out_min_reg <= min_new;
          out_max_reg <= max_new;
          min_reg     <= '0;
          max_reg     <= '0;
        end else if (active) begin
          min_reg <= min_new;
          max_reg <= max_new;
        end
      end

      assign out_min[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] = out_min_reg;
      assign out_max[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] = out_max_reg;
`else
      assign out_min[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] = '0;
      assign out_max[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] = '0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_multi_channel_integrator.sv
// Testbench for multi_channel_integrator. The reference model keeps each open
// window as a list of raw sample words and reduces that list when the window
// closes; expected results go into a queue that a negedge monitor drains on
// every valid/ready handshake.
module tb_multi_channel_integrator;
  localparam int NUM_CH = 4;
  localparam int IN_W   = 16;
  localparam int ACC_W  = 33;
  localparam int CNT_W  = 32;
  localparam longint SMAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (ACC_W-1));
  localparam longint QMAX = (longint'(1) <<< ACC_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*IN_W-1:0]   in_data;
  logic                     in_data_valid;
  logic                     int_start;
  logic                     int_stop;
  logic                     auto_mode;
  logic [CNT_W-1:0]         window_len;
  logic [NUM_CH*ACC_W-1:0]  out_data_sum;
  logic [NUM_CH*ACC_W-1:0]  out_data_sq;
  logic [CNT_W-1:0]         out_data_N;
  logic [NUM_CH-1:0]        out_sat;
  logic [NUM_CH*IN_W-1:0]   out_min;
  logic [NUM_CH*IN_W-1:0]   out_max;
  logic                     out_data_valid;
  logic                     out_data_ready;
  logic                     out_overrun;

  always #5 clk = ~clk;

  multi_channel_integrator #(
    .NUM_CH(NUM_CH), .IN_DATA_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_valid(in_data_valid),
    .int_start(int_start), .int_stop(int_stop), .auto_mode(auto_mode),
    .window_len(window_len), .out_data_sum(out_data_sum), .out_data_sq(out_data_sq),
    .out_data_N(out_data_N), .out_sat(out_sat), .out_min(out_min), .out_max(out_max),
    .out_data_valid(out_data_valid), .out_data_ready(out_data_ready),
    .out_overrun(out_overrun)
  );

  typedef struct packed {
    logic [NUM_CH*ACC_W-1:0] sum;
    logic [NUM_CH*ACC_W-1:0] sq;
    logic [CNT_W-1:0]        n;
    logic [NUM_CH-1:0]       sat;
    logic [NUM_CH*IN_W-1:0]  mn;
    logic [NUM_CH*IN_W-1:0]  mx;
    logic                    ovr;
  } result_t;

  result_t                exp_q[$];
  logic [NUM_CH*IN_W-1:0] win_samples[$];
  bit                     in_win;
  longint                 win_len;
  bit                     mon_en = 1'b0;
  int                     n_checks = 0;
  int                     n_pass = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic longint eff_len(input logic [CNT_W-1:0] w);
    return (w == '0) ? 64'd1 : longint'(w);
  endfunction

  // Reduce the sample list of a window with clamping arithmetic.
  function automatic result_t reduce_window();
    result_t r;
    longint s, q;
    int mn, mx, x;
    bit sat;
    logic [IN_W-1:0] raw;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s = 0; q = 0; mn = 0; mx = 0; sat = 1'b0;
      for (int i = 0; i < win_samples.size(); i++) begin
        raw = win_samples[i][k*IN_W +: IN_W];
        x = int'($signed(raw));
        s = s + x;
        if (s > SMAX) begin s = SMAX; sat = 1'b1; end
        else if (s < SMIN) begin s = SMIN; sat = 1'b1; end
        q = q + longint'(x) * longint'(x);
        if (q > QMAX) begin q = QMAX; sat = 1'b1; end
        if (i == 0) begin mn = x; mx = x; end
        else begin
          if (x < mn) mn = x;
          if (x > mx) mx = x;
        end
      end
      r.sum[k*ACC_W +: ACC_W] = s[ACC_W-1:0];
      r.sq[k*ACC_W +: ACC_W]  = q[ACC_W-1:0];
      r.sat[k] = sat;
`ifdef MCI_MINMAX_EN
      r.mn[k*IN_W +: IN_W] = mn[IN_W-1:0];
      r.mx[k*IN_W +: IN_W] = mx[IN_W-1:0];
`endif
    end
    r.n = CNT_W'(win_samples.size());
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs just sampled.
  task automatic model_step();
    bit close_now;
    result_t r;
    if (rst) begin
      in_win = 1'b0;
      win_samples.delete();
      exp_q.delete();
      return;
    end
    if (!in_win && int_start) begin
      in_win = 1'b1;
      win_samples.delete();
      win_len = eff_len(window_len);
    end
    if (in_win) begin
      if (in_data_valid) win_samples.push_back(in_data);
      close_now = int_stop ||
                  (auto_mode && in_data_valid && longint'(win_samples.size()) == win_len);
      if (close_now) begin
        r = reduce_window();
        // A result still queued here was never accepted: it is replaced.
        if (exp_q.size() > 0) begin
          r.ovr = 1'b1;
          exp_q[exp_q.size()-1] = r;
        end else begin
          r.ovr = 1'b0;
          exp_q.push_back(r);
        end
        win_samples.delete();
        if (int_stop) in_win = 1'b0;
        else win_len = eff_len(window_len);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", out_data_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) chk("overrun", out_overrun, exp_q[0].ovr);
      else chk("overrun_idle", out_overrun, 1'b0);
      if (out_data_valid && out_data_ready && exp_q.size() > 0) begin
        chk("sum", out_data_sum, exp_q[0].sum);
        chk("sq", out_data_sq, exp_q[0].sq);
        chk("n", out_data_N, exp_q[0].n);
        chk("sat", out_sat, exp_q[0].sat);
        chk("min", out_min, exp_q[0].mn);
        chk("max", out_max, exp_q[0].mx);
        $display("result N=%0d sum=%0h sq=%0h sat=%b ovr=%b", out_data_N,
                 out_data_sum, out_data_sq, out_sat, out_overrun);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input bit st, input bit sp, input bit vld, input logic [NUM_CH*IN_W-1:0] d);
    int_start = st; int_stop = sp; in_data_valid = vld; in_data = d;
    @(posedge clk);
    model_step();
    #1;
    int_start = 1'b0; int_stop = 1'b0; in_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1; int_start = 1'b0; int_stop = 1'b0; in_data_valid = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [NUM_CH*IN_W-1:0] lane_val(input int k, input int v);
    logic [NUM_CH*IN_W-1:0] d;
    d = '0;
    d[k*IN_W +: IN_W] = IN_W'(v);
    return d;
  endfunction

  initial begin
    logic [NUM_CH*IN_W-1:0] d;
    rst = 1'b1; in_data = '0; in_data_valid = 1'b0; int_start = 1'b0; int_stop = 1'b0;
    auto_mode = 1'b0; window_len = '0; out_data_ready = 1'b1;
    in_win = 1'b0; win_len = 1;
    repeat (2) begin @(posedge clk); model_step(); end
    #1 rst = 1'b0;
    chk("rst_sum", out_data_sum, 0);
    chk("rst_sq", out_data_sq, 0);
    chk("rst_n", out_data_N, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_min", out_min, 0);
    chk("rst_max", out_max, 0);
    chk("rst_valid", out_data_valid, 0);
    chk("rst_overrun", out_overrun, 0);
    mon_en = 1'b1;

    // Manual window 3, -5, 7 on lane 0.
    cyc(1'b1, 1'b0, 1'b1, lane_val(0, 3));
    cyc(1'b0, 1'b0, 1'b1, lane_val(0, -5));
    cyc(1'b0, 1'b1, 1'b1, lane_val(0, 7));
    chk("t1_valid", out_data_valid, 1'b1);
    chk("t1_n", out_data_N, 3);
    chk("t1_sum0", out_data_sum[0 +: ACC_W], 5);
    chk("t1_sq0", out_data_sq[0 +: ACC_W], 83);
    chk("t1_sum1", out_data_sum[ACC_W +: ACC_W], 0);
    idle(2);

    // Auto windows of 4 on lane 1, samples 1..8, then stop closes an empty window.
    auto_mode = 1'b1; window_len = 4;
    for (int i = 1; i <= 8; i++) cyc(i == 1, 1'b0, 1'b1, lane_val(1, i));
    cyc(1'b0, 1'b1, 1'b0, '0);
    auto_mode = 1'b0;
    idle(2);

    // Ready held low across two auto windows.
    out_data_ready = 1'b0; auto_mode = 1'b1; window_len = 2;
    cyc(1'b1, 1'b0, 1'b1, lane_val(0, 3));
    cyc(1'b0, 1'b0, 1'b1, lane_val(0, 4));
    cyc(1'b0, 1'b0, 1'b1, lane_val(0, -1));
    cyc(1'b0, 1'b0, 1'b1, lane_val(0, 2));
    chk("t3_valid", out_data_valid, 1'b1);
    chk("t3_overrun", out_overrun, 1'b1);
    out_data_ready = 1'b1;
    idle(1);
    out_data_ready = 1'b0;
    chk("t3_valid_clr", out_data_valid, 1'b0);
    chk("t3_overrun_clr", out_overrun, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    out_data_ready = 1'b1; auto_mode = 1'b0;
    idle(2);

    // Nine full-scale negative samples on lane 2 clamp its sum of squares.
    cyc(1'b1, 1'b0, 1'b1, lane_val(2, -32768));
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, lane_val(2, -32768));
    cyc(1'b0, 1'b1, 1'b1, lane_val(2, -32768));
    chk("t4_sat", out_sat, 4'b0100);
    chk("t4_sq2", out_data_sq[2*ACC_W +: ACC_W], QMAX);
    idle(2);

    // Start and stop in the same cycle, with and without a sample.
    cyc(1'b1, 1'b1, 1'b1, lane_val(0, 9));
    chk("t5_n", out_data_N, 1);
    chk("t5_sum0", out_data_sum[0 +: ACC_W], 9);
    chk("t5_sq0", out_data_sq[0 +: ACC_W], 81);
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("t5e_valid", out_data_valid, 1'b1);
    chk("t5e_n", out_data_N, 0);
    chk("t5e_sum", out_data_sum, 0);
    idle(2);

    // Reset after five samples, then a fresh window 4, -2, 6.
    cyc(1'b1, 1'b0, 1'b1, lane_val(3, 5));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, lane_val(3, 5));
    do_reset();
    chk("t6_valid", out_data_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, lane_val(0, 4));
    cyc(1'b0, 1'b0, 1'b1, lane_val(0, -2));
    cyc(1'b0, 1'b1, 1'b1, lane_val(0, 6));
    chk("t6_n", out_data_N, 3);
`ifdef MCI_MINMAX_EN
    chk("t6_min0", out_min[0 +: IN_W], 16'hfffe);
    chk("t6_max0", out_max[0 +: IN_W], 16'h0006);
`else
    chk("t6_min", out_min, 0);
`endif
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
      window_len = CNT_W'($urandom_range(0, 5));
      out_data_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NUM_CH; k++) begin
        case ($urandom_range(0, 5))
          0:       d[k*IN_W +: IN_W] = 16'h8000;
          1:       d[k*IN_W +: IN_W] = 16'h7fff;
          default: d[k*IN_W +: IN_W] = IN_W'($urandom());
        endcase
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc($urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
               $urandom_range(0, 3) != 0, d);
    end

    cyc(1'b0, 1'b1, 1'b0, '0);
    out_data_ready = 1'b1;
    idle(4);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", out_data_valid, 1'b0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
